muldiv_unit: RTL

Parametrised iterative multiply/divide unit with private HI/LO registers. It sits in the EX stage beside the ALU and replaces the single-cycle multiply and the always-enabled HI/LO registers. It also adds signed/unsigned division, mthi/mtlo writes, abort on flush, and a stall output that the hazard unit ORs into its PC/IF-ID hold.

---
 rtl/muldiv_pkg.sv | 28 ++
 rtl/muldiv_step.sv | 31 +++
 rtl/muldiv_unit.sv | 129 ++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings and helpers for the iterative multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'd0,
        OP_MULTU = 2'd1,
        OP_DIV   = 2'd2,
        OP_DIVU  = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_e;

    // Divide by zero: every quotient bit is this value; HI returns the raw dividend.
    localparam logic DIV0_LO_FILL = 1'b1;

    function automatic logic is_signed_op(input op_e o);
        return (o == OP_MULT) || (o == OP_DIV);
    endfunction

    function automatic logic is_div_op(input op_e o);
        return (o == OP_DIV) || (o == OP_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration over the {carry/remainder, low} accumulator:
// shift-add for multiply, restoring shift-subtract for divide.
module muldiv_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic               is_div,
    input  logic [2*WIDTH:0]   acc,
    input  logic [WIDTH-1:0]   operand,
    output logic [2*WIDTH:0]   acc_next
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [2*WIDTH:0] added;
    logic [2*WIDTH:0] shifted;

    always_comb begin
        sum      = acc[2*WIDTH:WIDTH] + (acc[0] ? {1'b0, operand} : '0);
        added    = {sum, acc[WIDTH-1:0]};
        shifted  = {acc[2*WIDTH-1:0], 1'b0};
        // Remainder stays below the divisor, so a set MSB means the trial went negative.
        diff     = shifted[2*WIDTH:WIDTH] - {1'b0, operand};
        acc_next = shifted;
        if (!is_div) begin
            acc_next = added >> 1;
        end else if (!diff[WIDTH]) begin
            acc_next = {diff, shifted[WIDTH-1:1], 1'b1};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with private HI/LO registers,
// mthi/mtlo writes, flush abort and a pipeline stall request.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             kill,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    input  logic             hi_read,
    input  logic             lo_read,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             stall
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    state_e             state, state_next;
    logic [CNT_W-1:0]   count;
    logic [2*WIDTH:0]   acc, acc_step;
    logic [WIDTH-1:0]   operand;
    logic [WIDTH-1:0]   a_raw;
    logic               is_div, neg_q, neg_r, div0;

    logic               sgn, a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quot, rem, res_hi, res_lo;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div   (is_div),
        .acc      (acc),
        .operand  (operand),
        .acc_next (acc_step)
    );

    assign busy  = (state != IDLE);
    assign stall = busy & (start | hi_read | lo_read | hi_we | lo_we);

    always_comb begin
        sgn   = is_signed_op(op_e'(op));
        a_neg = sgn & a[WIDTH-1];
        b_neg = sgn & b[WIDTH-1];
        a_mag = a_neg ? -a : a;
        b_mag = b_neg ? -b : b;
    end

    always_comb begin
        prod   = neg_q ? -acc[2*WIDTH-1:0] : acc[2*WIDTH-1:0];
        quot   = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem    = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        res_hi = prod[2*WIDTH-1:WIDTH];
        res_lo = prod[WIDTH-1:0];
        if (is_div) begin
            res_hi = div0 ? a_raw : rem;
            res_lo = div0 ? {WIDTH{DIV0_LO_FILL}} : quot;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (kill) state_next = IDLE;
                     else if (count == '0) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state   <= IDLE;
            hi      <= '0;
            lo      <= '0;
            done    <= 1'b0;
            count   <= '0;
            acc     <= '0;
            operand <= '0;
            a_raw   <= '0;
            is_div  <= 1'b0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            div0    <= 1'b0;
        end else begin
            state <= state_next;
            done  <= (state == FIX) && !kill;
            case (state)
                IDLE: begin
                    if (hi_we) hi <= wdata;
                    if (lo_we) lo <= wdata;
                    if (start) begin
                        acc     <= {{(WIDTH+1){1'b0}}, a_mag};
                        operand <= b_mag;
                        a_raw   <= a;
                        is_div  <= is_div_op(op_e'(op));
                        neg_q   <= a_neg ^ b_neg;
                        neg_r   <= a_neg;
                        div0    <= (b == '0);
                        count   <= CNT_W'(WIDTH - 1);
                    end
                end
                RUN: begin
                    acc   <= acc_step;
                    count <= count - CNT_W'(1);
                end
                FIX: begin
                    if (!kill) begin
                        hi <= res_hi;
                        lo <= res_lo;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
